// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: a single CHUNK-wide carry-lookahead adder is reused once per cycle, LSB chunk first.
// Optional macro CLA_SEQ_SUB_EN adds the in_sub port (A-B computed as A + ~B + 1).

module cla_seq_adder_cla #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    localparam int unsigned NG = W / 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic [3:0]   gg;
    logic [3:0]   pp;
    logic         cg;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // 4-bit lookahead groups; the group carry cg links consecutive groups
    always_comb begin
        c  = '0;
        gg = '0;
        pp = '0;
        cg = cin_i;
        for (int unsigned i = 0; i < NG; i++) begin
            gg = g[4*i +: 4];
            pp = p[4*i +: 4];
            c[4*i]   = cg;
            c[4*i+1] = gg[0] | (pp[0] & cg);
            c[4*i+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg);
            c[4*i+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & cg);
            cg = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cg);
        end
    end

    assign sum_o  = p ^ c;
    assign cout_o = cg;
endmodule

module cla_seq_adder #(
    parameter int OP_WIDTH = 128,
    parameter int CHUNK    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] in_a,
    input  logic [OP_WIDTH-1:0] in_b,
    input  logic                in_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] out_sum,
    output logic                out_cout,
    output logic                busy
);
    localparam int NCHUNK = OP_WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic                  carry_q;
    logic [OP_WIDTH-1:0]   a_q;
    logic [OP_WIDTH-1:0]   b_q;
    logic [OP_WIDTH-1:0]   sum_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [OP_WIDTH-1:0]   b_d;
    logic                  carry_d;
    logic [CHUNK-1:0]      chunk_sum;
    logic                  chunk_cout;

`ifdef CLA_SEQ_SUB_EN
    always_comb begin
        b_d     = in_sub ? ~in_b : in_b;
        carry_d = in_sub ? 1'b1 : in_cin;
    end
`else
    always_comb begin
        b_d     = in_b;
        carry_d = in_cin;
    end
`endif

    cla_seq_adder_cla #(
        .W (CHUNK)
    ) u_cla (
        .a_i    (a_q[idx_q*CHUNK +: CHUNK]),
        .b_i    (b_q[idx_q*CHUNK +: CHUNK]),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= b_d;
                        carry_q    <= carry_d;
                        idx_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum;
                    carry_q                     <= chunk_cout;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // in_valid is deliberately ignored here; acceptance waits for IDLE
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign busy      = busy_q;
endmodule
